// File: rtl/cdc_gray_pkg.sv
// Shared types and Gray-code helpers for the asynchronous-FIFO pointer logic.
package cdc_gray_pkg;

   // Pointer role: write side reports full, read side reports empty.
   typedef enum logic {PTR_WR, PTR_RD} ptr_mode_e;

   // Helpers work on a wide vector; callers zero-extend narrower pointers
   // and truncate the result. Leading zeros do not disturb either mapping.
   localparam int unsigned GRAY_MAX_W = 32;

   function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // XOR prefix from the MSB downward.
   function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
      logic [GRAY_MAX_W-1:0] b;
      b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
      for (int i = GRAY_MAX_W-2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/gray_ptr_gen.sv
// Registered Gray-code FIFO pointer with full/empty, almost flag and level,
// evaluated against the opposite domain's synchronised Gray pointer.
module gray_ptr_gen
   import cdc_gray_pkg::*;
#(
   parameter int unsigned ADDR_W = 4,
   parameter ptr_mode_e   MODE   = PTR_WR,
   parameter int unsigned MARGIN = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inc,
   input  logic [ADDR_W:0]   sync_ptr_gray,
   output logic [ADDR_W:0]   ptr_gray,
   output logic [ADDR_W-1:0] addr,
   output logic              flag,
   output logic              almost,
   output logic [ADDR_W:0]   level
);

   localparam int unsigned PW    = ADDR_W + 1;
   localparam int unsigned DEPTH = 2**ADDR_W;
   localparam logic [ADDR_W:0] AF_TH = PW'(DEPTH - MARGIN);
   localparam logic [ADDR_W:0] AE_TH = PW'(MARGIN);
   // Empty is the reset condition on the read side, so its flags start set.
   localparam logic RST_FLAG = (MODE == PTR_RD);

   logic [ADDR_W:0] bin_q, bin_d;
   logic [ADDR_W:0] gray_q, gray_d;
   logic [ADDR_W:0] level_q, level_d;
   logic            flag_q, flag_d;
   logic            almost_q, almost_d;
   logic [ADDR_W:0] sync_bin;
   logic [ADDR_W:0] full_cmp;
   logic            adv;

   assign sync_bin = PW'(gray2bin(GRAY_MAX_W'(sync_ptr_gray)));
   // Write pointer is one lap ahead when full: top two Gray bits inverted.
   assign full_cmp = {~sync_ptr_gray[ADDR_W:ADDR_W-1], sync_ptr_gray[ADDR_W-2:0]};

   // Next pointer and status; flags use the post-advance pointer so they
   // track the same edge as the pointer itself.
   always_comb begin
      adv      = inc & ~flag_q;
      bin_d    = bin_q + {{ADDR_W{1'b0}}, adv};
      gray_d   = PW'(bin2gray(GRAY_MAX_W'(bin_d)));
      flag_d   = 1'b0;
      level_d  = '0;
      almost_d = 1'b0;
      if (MODE == PTR_WR) begin
         flag_d   = (gray_d == full_cmp);
         level_d  = bin_d - sync_bin;
         almost_d = (level_d >= AF_TH);
      end else begin
         flag_d   = (gray_d == sync_ptr_gray);
         level_d  = sync_bin - bin_d;
         almost_d = (level_d <= AE_TH);
      end
   end

   // State register; reset wins over any advance request.
   always_ff @(posedge clk) begin
      if (rst) begin
         bin_q    <= '0;
         gray_q   <= '0;
         level_q  <= '0;
         flag_q   <= RST_FLAG;
         almost_q <= RST_FLAG;
      end else begin
         bin_q    <= bin_d;
         gray_q   <= gray_d;
         level_q  <= level_d;
         flag_q   <= flag_d;
         almost_q <= almost_d;
      end
   end

   assign ptr_gray = gray_q;
   assign addr     = bin_q[ADDR_W-1:0];
   assign flag     = flag_q;
   assign almost   = almost_q;
   assign level    = level_q;

endmodule
